shf_left_arbiter: RTL and testbench

Shares one left barrel shifter (SHF_left) between NUM_REQ normalization requesters, e.g. the FP add/sub units of the FFT butterflies. Requesters use a per-port valid/ready handshake and are granted round-robin, at most one request per cycle. The shifted result is registered and returned on a single valid/ready response channel, tagged with the requester ID. Sits in FPU_COMMON between the FP adders' leading-zero counters and their rounding stages.

---
 rtl/shf_left_arbiter_pkg.sv | 24 ++
 rtl/shf_left_arbiter_rr_arb.sv | 40 ++++
 rtl/shf_left_arbiter_shf_left.sv | 35 +++
 rtl/shf_left_arbiter.sv | 162 ++++++++++++++++
 tb/tb_shf_left_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shf_left_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shf_pkg
// Shared definitions for the left-shifter arbiter slice of FPU_COMMON.
//   SHF_NUM_REQ_MAX : largest supported number of requesters
//   shf_id_w(n)     : tag width needed to name n requesters (at least 1 bit)
//   shf_req_t       : {data, shift} pair a requester packs into its slice
// ---------------------------------------------------------------------------
package shf_pkg;

  localparam int SHF_NUM_REQ_MAX    = 8;
  localparam int SHF_SIZE_DATA_DEF  = 32;
  localparam int SHF_SIZE_SHIFT_DEF = 5;

  // A single requester still needs a 1-bit tag so ports never collapse to zero width.
  function automatic int shf_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [SHF_SIZE_DATA_DEF-1:0]  data;
    logic [SHF_SIZE_SHIFT_DEF-1:0] shift;
  } shf_req_t;

endpackage

// File: rtl/shf_left_arbiter_rr_arb.sv
// ---------------------------------------------------------------------------
// shf_rr_arb
// Combinational round-robin priority picker, shared by FPU_COMMON resources.
// Ports:
//   valid : request vector
//   ptr   : requester with highest priority this cycle (must be < N)
//   grant : one-hot grant, zero when nothing is valid
//   idx   : encoded index of the granted requester (0 when none)
//   any   : some requester is granted
// ---------------------------------------------------------------------------
module shf_rr_arb #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Walk the requesters starting at ptr and wrapping; the first valid one wins.
  always_comb begin : pick
    logic found;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && valid[k] && (k == ((int'(ptr) + off) % N))) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          idx      = ID_W'(k);
        end
      end
    end
    any = found;
  end

endmodule

// File: rtl/shf_left_arbiter_shf_left.sv
// ---------------------------------------------------------------------------
// SHF_left
// Combinational logical left barrel shifter, zero fill.
// Ports:
//   data   : operand
//   shift  : shift amount (0 passes data through)
//   result : data << shift, bits past the MSB are dropped
//   lost   : (SHF_ARB_FLAGS_EN only) a 1 bit was shifted out past the MSB
// Optional feature macro: SHF_ARB_FLAGS_EN
// ---------------------------------------------------------------------------
module SHF_left #(
  parameter int SIZE_DATA  = 32,
  parameter int SIZE_SHIFT = 5
) (
  input  logic [SIZE_DATA-1:0]  data,
  input  logic [SIZE_SHIFT-1:0] shift,
  output logic [SIZE_DATA-1:0]  result
`ifdef SHF_ARB_FLAGS_EN
  ,
  output logic                  lost
`endif
);

  assign result = data << shift;

`ifdef SHF_ARB_FLAGS_EN
  // Only the low (SIZE_DATA - shift) bits survive; any 1 above them is lost.
  // A mask avoids a double-width shift that could itself overflow for
  // shift amounts approaching 2*SIZE_DATA.
  logic [SIZE_DATA-1:0] keep;
  assign keep = {SIZE_DATA{1'b1}} >> shift;
  assign lost = |(data & ~keep);
`endif

endmodule

// File: rtl/shf_left_arbiter.sv
// ---------------------------------------------------------------------------
// shf_left_arbiter
// Shares one SHF_left barrel shifter between NUM_REQ normalization
// requesters. Round-robin grant, one request per cycle, registered result
// returned on a single valid/ready channel tagged with the requester index.
// Ports:
//   i_clk, i_rst    : clock (rising edge), synchronous active-high reset
//   i_req_valid     : per-requester request valid
//   o_req_ready     : per-requester accept (one-hot or zero)
//   i_req_data      : packed operands, requester k in slice k
//   i_req_shift     : packed shift amounts, requester k in slice k
//   o_rsp_valid     : response valid
//   i_rsp_ready     : downstream accept
//   o_rsp_data      : shifted result
//   o_rsp_id        : requester that produced o_rsp_data
//   o_busy          : response pending or any request valid
//   o_rsp_zero      : (SHF_ARB_FLAGS_EN) result is zero
//   o_rsp_lost      : (SHF_ARB_FLAGS_EN) a 1 bit was shifted out
// Optional feature macro: SHF_ARB_FLAGS_EN
// ---------------------------------------------------------------------------
module shf_left_arbiter
  import shf_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int SIZE_DATA  = 32,
  parameter  int SIZE_SHIFT = 5,
  localparam int ID_W       = shf_id_w(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_data,
  input  logic [NUM_REQ*SIZE_SHIFT-1:0] i_req_shift,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [SIZE_DATA-1:0]          o_rsp_data,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic                          o_busy
`ifdef SHF_ARB_FLAGS_EN
  ,
  output logic                          o_rsp_zero,
  output logic                          o_rsp_lost
`endif
);

  logic                  out_valid;
  logic [SIZE_DATA-1:0]  rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       ptr_next;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gidx;
  logic                  any_grant;
  logic                  can_load;
  logic                  xfer;
  logic [SIZE_DATA-1:0]  sel_data;
  logic [SIZE_SHIFT-1:0] sel_shift;
  logic [SIZE_DATA-1:0]  shifted;

  shf_rr_arb #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .valid (i_req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_grant)
  );

  // Grant is one-hot, so an OR-style mux over the slices picks the operand.
  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_data  = i_req_data[k*SIZE_DATA +: SIZE_DATA];
        sel_shift = i_req_shift[k*SIZE_SHIFT +: SIZE_SHIFT];
      end
    end
  end

`ifdef SHF_ARB_FLAGS_EN
  logic shf_lost;
  logic rsp_zero;
  logic rsp_lost;

  SHF_left #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_SHIFT (SIZE_SHIFT)
  ) u_shf (
    .data   (sel_data),
    .shift  (sel_shift),
    .result (shifted),
    .lost   (shf_lost)
  );
`else
  SHF_left #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_SHIFT (SIZE_SHIFT)
  ) u_shf (
    .data   (sel_data),
    .shift  (sel_shift),
    .result (shifted)
  );
`endif

  // The output slot can take a new result when empty or being drained this
  // cycle, which gives back-to-back results without a bubble.
  assign can_load    = ~out_valid | i_rsp_ready;
  assign xfer        = can_load & any_grant & ~i_rst;
  assign o_req_ready = xfer ? grant : '0;

  // Priority moves to the requester after the one just served.
  always_comb begin
    ptr_next = gidx + ID_W'(1);
    if (gidx == ID_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Output register and round-robin pointer; a reset drops any pending result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      rsp_data  <= shifted;
      rsp_id    <= gidx;
      rr_ptr    <= ptr_next;
    end else if (i_rsp_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHF_ARB_FLAGS_EN
  // Flags travel with the data so they always describe o_rsp_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_zero <= 1'b0;
      rsp_lost <= 1'b0;
    end else if (xfer) begin
      rsp_zero <= (shifted == '0);
      rsp_lost <= shf_lost;
    end
  end

  assign o_rsp_zero = rsp_zero;
  assign o_rsp_lost = rsp_lost;
`endif

  assign o_rsp_valid = out_valid;
  assign o_rsp_data  = rsp_data;
  assign o_rsp_id    = rsp_id;
  assign o_busy      = out_valid | (|i_req_valid);

endmodule

// File: tb/tb_shf_left_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shf_left_arbiter
// Directed bench for shf_left_arbiter (NUM_REQ=4, 32-bit data, 5-bit shift)
// with a cycle-level reference model compared on every falling edge plus
// hand-computed checkpoints. Optional feature macro: SHF_ARB_FLAGS_EN
// ---------------------------------------------------------------------------
module tb_shf_left_arbiter;
  import shf_pkg::*;

  localparam int NREQ = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    reqValid;
  logic [3:0]    reqReady;
  logic [127:0]  reqData;
  logic [19:0]   reqShift;
  logic          rspValid;
  logic          rspReady;
  logic [31:0]   rspData;
  logic [1:0]    rspId;
  logic          busy;
`ifdef SHF_ARB_FLAGS_EN
  logic          rspZero;
  logic          rspLost;
`endif

  shf_req_t reqs [NREQ];

  int testsRun  = 0;
  int failCount = 0;

  shf_left_arbiter #(
    .NUM_REQ    (4),
    .SIZE_DATA  (32),
    .SIZE_SHIFT (5)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_data  (reqData),
    .i_req_shift (reqShift),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_data  (rspData),
    .o_rsp_id    (rspId),
    .o_busy      (busy)
`ifdef SHF_ARB_FLAGS_EN
    ,
    .o_rsp_zero  (rspZero),
    .o_rsp_lost  (rspLost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-requester records onto the DUT buses.
  always_comb begin
    reqData  = '0;
    reqShift = '0;
    for (int k = 0; k < NREQ; k++) begin
      reqData[k*32 +: 32] = reqs[k].data;
      reqShift[k*5 +: 5]  = reqs[k].shift;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    reqValid = valid;
    rspReady = ready;
  endtask

  task automatic setReq(input int k, input logic [31:0] d, input logic [4:0] s);
    reqs[k].data  = d;
    reqs[k].shift = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit          modelLive = 0;
  bit          mValid;
  logic [31:0] mData;
  int          mId;
  int          mPtr;
  bit          mZero;
  bit          mLost;

  // First valid requester at or after ptr, wrapping; -1 if none.
  function automatic int pickReq(input logic [3:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      int k;
      k = (ptr + off) % NREQ;
      if (((v >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    logic [63:0] wide;
    modelLive = 1;
    if (rst) begin
      mValid = 0; mData = '0; mId = 0; mPtr = 0; mZero = 0; mLost = 0;
    end else begin
      g = pickReq(reqValid, mPtr);
      if ((!mValid || rspReady) && g >= 0) begin
        wide   = {32'd0, reqs[g].data} << reqs[g].shift;
        mData  = wide[31:0];
        mLost  = (wide[63:32] != 0);
        mZero  = (wide[31:0] == 0);
        mId    = g;
        mValid = 1;
        mPtr   = (g + 1) % NREQ;
      end else if (rspReady) begin
        mValid = 0;
      end
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    int g;
    logic [3:0] expReady;
    if (modelLive) begin
      g = pickReq(reqValid, mPtr);
      expReady = 4'd0;
      if (!rst && (!mValid || rspReady) && g >= 0) expReady = 4'd1 << g;
      checkOutput("model_req_ready", 64'(reqReady), 64'(expReady));
      checkOutput("model_rsp_valid", 64'(rspValid), 64'(mValid));
      checkOutput("model_busy", 64'(busy), 64'(mValid || (reqValid != 0)));
      if (mValid) begin
        checkOutput("model_rsp_data", 64'(rspData), 64'(mData));
        checkOutput("model_rsp_id", 64'(rspId), 64'(mId));
`ifdef SHF_ARB_FLAGS_EN
        checkOutput("model_rsp_zero", 64'(rspZero), 64'(mZero));
        checkOutput("model_rsp_lost", 64'(rspLost), 64'(mLost));
`endif
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int expSeq [6];
    int grants;
    bit got2;
    bit prev0;
    bit double0;

    expSeq = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < NREQ; k++) setReq(k, 32'h0, 5'd0);
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1);

    // Reset: no accepts while in reset, outputs cleared afterwards.
    @(negedge clk);
    checkOutput("ready_in_reset", 64'(reqReady), 64'h0);
    tick();
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 64'(rspValid), 64'h0);
    checkOutput("reset_rsp_data", 64'(rspData), 64'h0);
    checkOutput("reset_rsp_id", 64'(rspId), 64'h0);

    // All requesters valid: ids rotate with no bubbles.
    for (int k = 0; k < NREQ; k++) setReq(k, 32'h10 + k, 5'(k));
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      checkOutput("rotate_valid", 64'(rspValid), 64'h1);
      checkOutput("rotate_id", 64'(rspId), 64'(expSeq[i]));
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("drain_valid", 64'(rspValid), 64'h0);

    // Single request from requester 1.
    setReq(1, 32'h0000_00F1, 5'd4);
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("single_ready", 64'(reqReady), 64'h2);
    tick();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("single_valid", 64'(rspValid), 64'h1);
    checkOutput("single_data", 64'(rspData), 64'h0000_0F10);
    checkOutput("single_id", 64'(rspId), 64'h1);

    // Backpressure with a pending id=2 result of 0x80000000.
    setReq(2, 32'h0000_0001, 5'd31);
    applyStimulus(4'b0100, 1'b1);
    tick();
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_ready", 64'(reqReady), 64'h0);
      checkOutput("bp_data", 64'(rspData), 64'h8000_0000);
      checkOutput("bp_id", 64'(rspId), 64'h2);
      tick();
    end
    applyStimulus(4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_ready", 64'(reqReady), 64'h8);
    tick();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_id", 64'(rspId), 64'h3);
    tick();

    // Boundary shifts on requester 0.
    setReq(0, 32'hFFFF_FFFF, 5'd31);
    applyStimulus(4'b0001, 1'b1);
    tick();
    setReq(0, 32'hFFFF_FFFF, 5'd0);
    @(negedge clk);
    checkOutput("shift31_data", 64'(rspData), 64'h8000_0000);
`ifdef SHF_ARB_FLAGS_EN
    checkOutput("shift31_lost", 64'(rspLost), 64'h1);
`endif
    tick();
    setReq(0, 32'h0000_0002, 5'd31);
    @(negedge clk);
    checkOutput("shift0_data", 64'(rspData), 64'hFFFF_FFFF);
`ifdef SHF_ARB_FLAGS_EN
    checkOutput("shift0_lost", 64'(rspLost), 64'h0);
`endif
    tick();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("shift_out_all_data", 64'(rspData), 64'h0);
`ifdef SHF_ARB_FLAGS_EN
    checkOutput("shift_out_all_zero", 64'(rspZero), 64'h1);
`endif

    // Fairness: park the pointer at 0, then req0 always valid, req2 once.
    setReq(3, 32'h0000_0003, 5'd1);
    applyStimulus(4'b1000, 1'b1);
    tick();
    setReq(0, 32'h0000_0A0A, 5'd2);
    setReq(2, 32'h0000_0B0B, 5'd3);
    applyStimulus(4'b0101, 1'b1);
    grants = 0; got2 = 0; prev0 = 0; double0 = 0;
    for (int i = 0; i < 4 && !got2; i++) begin
      @(negedge clk);
      if (reqReady[0]) begin
        if (prev0) double0 = 1;
        prev0 = 1;
        grants++;
      end else if (reqReady[2]) begin
        got2 = 1;
        grants++;
      end
      tick();
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("fair_req2_granted", 64'(got2 && grants <= 2), 64'h1);
    checkOutput("fair_no_double_req0", 64'(double0), 64'h0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();

    // Reset mid-stream with a stalled response.
    setReq(1, 32'h0000_0005, 5'd1);
    applyStimulus(4'b0010, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("midrst_valid", 64'(rspValid), 64'h0);
    checkOutput("midrst_grant0", 64'(reqReady), 64'h1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("midrst_id", 64'(rspId), 64'h0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
